// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants, state encoding and baud helper for the parametrised UART receiver
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK
    } rx_state_t;

    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - two-flop synchronizer for the serial line with falling-edge detect
module uart_rx_sync (
    input  logic clk,
    input  logic reset,
    input  logic rxd,
    output logic rxs,
    output logic fall
);

    logic s1_q, s2_q, prev_q;

    // Flops reset to 1 so an idle line never looks like a start edge after reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_q   <= 1'b1;
            s2_q   <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            s1_q   <= rxd;
            s2_q   <= s1_q;
            prev_q <= s2_q;
        end
    end

    assign rxs  = s2_q;
    assign fall = prev_q & ~s2_q;

endmodule

// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - parametrised UART receiver with valid/ready output; UART_RX_BREAK_DET_EN adds break detection
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int CLK_HZ    = 54000000,
    parameter int BAUD      = 9600,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rxd,
    input  logic                 rx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 busy
`ifdef UART_RX_BREAK_DET_EN
    ,
    output logic                 rx_break
`endif
);

    localparam int              CPB       = clks_per_bit(CLK_HZ, BAUD);
    localparam int              CW        = $clog2(CPB + 1);
    localparam logic [CW-1:0]   MID_START = CW'(CPB / 2 - 1);
    localparam logic [CW-1:0]   MID_BIT   = CW'(CPB - 1);
    localparam logic [3:0]      LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]      LAST_STOP = 4'(STOP_BITS - 1);

    rx_state_t              state_q, state_d;
    logic [CW-1:0]          bit_clk_q, bit_clk_d;
    logic [3:0]             idx_q, idx_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d, data_q, data_d;
    logic                   ferr_q, ferr_d, perr_q, perr_d;
    logic                   valid_q, valid_d, fe_q, fe_d, pe_q, pe_d, ov_q, ov_d;
    logic                   rxs, fall, tick, is_break, deliver;

    uart_rx_sync u_sync (
        .clk   (clk),
        .reset (reset),
        .rxd   (rxd),
        .rxs   (rxs),
        .fall  (fall)
    );

    assign tick = (state_q == ST_START) ? (bit_clk_q == MID_START) : (bit_clk_q == MID_BIT);

`ifdef UART_RX_BREAK_DET_EN
    logic any_one_q, any_one_d, rx_break_q;

    // Break = nothing but zeros from start bit through the first stop bit.
    assign is_break = (state_q == ST_STOP) && (idx_q == 4'd0) && !any_one_q && !rxs;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            any_one_q  <= 1'b0;
            rx_break_q <= 1'b0;
        end else begin
            any_one_q  <= any_one_d;
            rx_break_q <= (state_d == ST_BREAK);
        end
    end

    assign rx_break = rx_break_q;
`else
    assign is_break = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            bit_clk_q <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            ferr_q    <= 1'b0;
            perr_q    <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            fe_q      <= 1'b0;
            pe_q      <= 1'b0;
            ov_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_clk_q <= bit_clk_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            ferr_q    <= ferr_d;
            perr_q    <= perr_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            fe_q      <= fe_d;
            pe_q      <= pe_d;
            ov_q      <= ov_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (fall) state_d = ST_START;
            ST_START:  if (tick) state_d = rxs ? ST_IDLE : ST_DATA;
            ST_DATA:   if (tick && idx_q == LAST_DATA)
                           state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
            ST_PARITY: if (tick) state_d = ST_STOP;
            ST_STOP: begin
                if (tick && idx_q == LAST_STOP) state_d = ST_IDLE;
`ifdef UART_RX_BREAK_DET_EN
                if (tick && is_break) state_d = ST_BREAK;
`endif
            end
`ifdef UART_RX_BREAK_DET_EN
            ST_BREAK:  if (rxs) state_d = ST_IDLE;
`endif
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bit_clk_d = bit_clk_q + 1'b1;
        idx_d     = idx_q;
        shift_d   = shift_q;
        ferr_d    = ferr_q;
        perr_d    = perr_q;
        data_d    = data_q;
        valid_d   = valid_q;
        fe_d      = fe_q;
        pe_d      = pe_q;
        ov_d      = ov_q;
        deliver   = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
        any_one_d = any_one_q;
        if (state_q == ST_IDLE)
            any_one_d = 1'b0;
        else if ((state_q == ST_DATA || state_q == ST_PARITY) && tick && rxs)
            any_one_d = 1'b1;
`endif
        if (state_q == ST_IDLE || state_q == ST_BREAK || tick)
            bit_clk_d = '0;

        case (state_q)
            ST_IDLE: begin
                idx_d  = '0;
                ferr_d = 1'b0;
                perr_d = 1'b0;
            end
            ST_DATA: if (tick) begin
                // LSB arrives first, so shift in from the top.
                shift_d = {rxs, shift_q[DATA_BITS-1:1]};
                idx_d   = (idx_q == LAST_DATA) ? 4'd0 : idx_q + 4'd1;
            end
            ST_PARITY: if (tick)
                perr_d = ((^shift_q) ^ rxs) != (PARITY == PAR_ODD);
            ST_STOP: if (tick) begin
                ferr_d  = ferr_q | ~rxs;
                idx_d   = idx_q + 4'd1;
                deliver = (idx_q == LAST_STOP) && !is_break;
            end
            default: ;
        endcase

        if (deliver) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            fe_d    = ferr_d;
            pe_d    = perr_q;
            ov_d    = valid_q & ~rx_ready;
        end else if (valid_q && rx_ready) begin
            valid_d = 1'b0;
            fe_d    = 1'b0;
            pe_d    = 1'b0;
            ov_d    = 1'b0;
        end
    end

    assign rx_data    = data_q;
    assign rx_valid   = valid_q;
    assign frame_err  = fe_q;
    assign parity_err = pe_q;
    assign overrun    = ov_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// tb/tb_uart_rx_param.sv - directed bench for uart_rx_param at 10 clocks per bit
module tb_uart_rx_param;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic rxd_a = 1'b1, rxd_b = 1'b1, rxd_c = 1'b1;
    logic rdy_a = 1'b1, rdy_b = 1'b1, rdy_c = 1'b1;
    logic [7:0] data_a, data_c;
    logic [6:0] data_b;
    logic val_a, val_b, val_c, fe_a, fe_b, fe_c, pe_a, pe_b, pe_c;
    logic ov_a, ov_b, ov_c, busy_a, busy_b, busy_c;
`ifdef UART_RX_BREAK_DET_EN
    logic brk_a, brk_b, brk_c;
`endif

    int checks = 0;
    int errors = 0;
    int vcnt_a = 0, vcnt_b = 0, vcnt_c = 0;
    logic [7:0] cap_a = '0, cap_c = '0;
    logic [6:0] cap_b = '0;
    logic [2:0] flg_a = '0, flg_b = '0, flg_c = '0;

    always #5 clk = ~clk;

    uart_rx_param #(.CLK_HZ(1000000), .BAUD(100000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_a (
        .clk(clk), .reset(reset), .rxd(rxd_a), .rx_ready(rdy_a), .rx_data(data_a), .rx_valid(val_a),
        .frame_err(fe_a), .parity_err(pe_a), .overrun(ov_a), .busy(busy_a)
`ifdef UART_RX_BREAK_DET_EN
        , .rx_break(brk_a)
`endif
    );

    uart_rx_param #(.CLK_HZ(1000000), .BAUD(100000), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)) u_b (
        .clk(clk), .reset(reset), .rxd(rxd_b), .rx_ready(rdy_b), .rx_data(data_b), .rx_valid(val_b),
        .frame_err(fe_b), .parity_err(pe_b), .overrun(ov_b), .busy(busy_b)
`ifdef UART_RX_BREAK_DET_EN
        , .rx_break(brk_b)
`endif
    );

    uart_rx_param #(.CLK_HZ(1000000), .BAUD(100000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_c (
        .clk(clk), .reset(reset), .rxd(rxd_c), .rx_ready(rdy_c), .rx_data(data_c), .rx_valid(val_c),
        .frame_err(fe_c), .parity_err(pe_c), .overrun(ov_c), .busy(busy_c)
`ifdef UART_RX_BREAK_DET_EN
        , .rx_break(brk_c)
`endif
    );

    // Every clock with rx_valid high is counted and its word/flags {fe,pe,ov} captured.
    always @(negedge clk) begin
        if (val_a) begin vcnt_a++; cap_a = data_a; flg_a = {fe_a, pe_a, ov_a}; end
        if (val_b) begin vcnt_b++; cap_b = data_b; flg_b = {fe_b, pe_b, ov_b}; end
        if (val_c) begin vcnt_c++; cap_c = data_c; flg_c = {fe_c, pe_c, ov_c}; end
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input int ch, input logic v);
        case (ch)
            0:       rxd_a = v;
            1:       rxd_b = v;
            default: rxd_c = v;
        endcase
    endtask

    // ch0: 8N1, ch1: 7 data + even parity + 1 stop, ch2: 8 data + 2 stop. stops[0] is the first stop bit.
    task automatic send_frame(input int ch, input logic [7:0] d, input logic par, input logic [1:0] stops);
        int nb;
        nb = (ch == 1) ? 7 : 8;
        drive(ch, 1'b0); wait_clks(10);
        for (int i = 0; i < nb; i++) begin drive(ch, d[i]); wait_clks(10); end
        if (ch == 1) begin drive(ch, par); wait_clks(10); end
        drive(ch, stops[0]); wait_clks(10);
        if (ch == 2) begin drive(ch, stops[1]); wait_clks(10); end
        drive(ch, 1'b1);
    endtask

    task automatic test_reset;
        wait_clks(4);
        checks++; if (val_a !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", val_a); end
        checks++; if (data_a !== 8'h00) begin errors++; $display("FAIL reset_data: got %h exp 00", data_a); end
        checks++; if ({fe_a, pe_a, ov_a} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b exp 000", {fe_a, pe_a, ov_a}); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", busy_a); end
`ifdef UART_RX_BREAK_DET_EN
        checks++; if (brk_a !== 1'b0) begin errors++; $display("FAIL reset_break: got %b exp 0", brk_a); end
`endif
        reset = 1'b1;
        wait_clks(20);
    endtask

    task automatic test_basic;
        logic [7:0] vals [4] = '{8'hA5, 8'hFF, 8'h01, 8'h80};
        for (int k = 0; k < 4; k++) begin
            vcnt_a = 0;
            send_frame(0, vals[k], 1'b0, 2'b11);
            wait_clks(10);
            checks++; if (vcnt_a !== 1) begin errors++; $display("FAIL basic_pulse[%0d]: got %0d valid clks exp 1", k, vcnt_a); end
            checks++; if (cap_a !== vals[k]) begin errors++; $display("FAIL basic_data[%0d]: got %h exp %h", k, cap_a, vals[k]); end
            checks++; if (flg_a !== 3'b000) begin errors++; $display("FAIL basic_flags[%0d]: got %b exp 000", k, flg_a); end
            checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL basic_busy[%0d]: got %b exp 0", k, busy_a); end
        end
    endtask

    task automatic test_back_to_back;
        vcnt_a = 0;
        send_frame(0, 8'h5A, 1'b0, 2'b11);
        checks++; if (cap_a !== 8'h5A) begin errors++; $display("FAIL b2b_first: got %h exp 5a", cap_a); end
        send_frame(0, 8'hC3, 1'b0, 2'b11);
        wait_clks(10);
        checks++; if (vcnt_a !== 2) begin errors++; $display("FAIL b2b_count: got %0d exp 2", vcnt_a); end
        checks++; if (cap_a !== 8'hC3) begin errors++; $display("FAIL b2b_second: got %h exp c3", cap_a); end
    endtask

    task automatic test_parity;
        logic [6:0] d   [4] = '{7'h41, 7'h41, 7'h43, 7'h43};
        logic       par [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic       exp [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        for (int k = 0; k < 4; k++) begin
            vcnt_b = 0;
            send_frame(1, {1'b0, d[k]}, par[k], 2'b11);
            wait_clks(10);
            checks++; if (vcnt_b !== 1) begin errors++; $display("FAIL par_pulse[%0d]: got %0d exp 1", k, vcnt_b); end
            checks++; if (cap_b !== d[k]) begin errors++; $display("FAIL par_data[%0d]: got %h exp %h", k, cap_b, d[k]); end
            checks++; if (flg_b !== {1'b0, exp[k], 1'b0}) begin errors++; $display("FAIL par_flags[%0d]: got %b exp %b", k, flg_b, {1'b0, exp[k], 1'b0}); end
        end
        checks++; if (busy_b !== 1'b0) begin errors++; $display("FAIL par_busy: got %b exp 0", busy_b); end
    endtask

    task automatic test_two_stop;
        logic [1:0] st  [3] = '{2'b11, 2'b01, 2'b10};
        logic       exp [3] = '{1'b0, 1'b1, 1'b1};
        for (int k = 0; k < 3; k++) begin
            vcnt_c = 0;
            send_frame(2, 8'h3C, 1'b0, st[k]);
            wait_clks(10);
            checks++; if (vcnt_c !== 1) begin errors++; $display("FAIL stop2_pulse[%0d]: got %0d exp 1", k, vcnt_c); end
            checks++; if (cap_c !== 8'h3C) begin errors++; $display("FAIL stop2_data[%0d]: got %h exp 3c", k, cap_c); end
            checks++; if (flg_c !== {exp[k], 2'b00}) begin errors++; $display("FAIL stop2_flags[%0d]: got %b exp %b", k, flg_c, {exp[k], 2'b00}); end
        end
        checks++; if (busy_c !== 1'b0) begin errors++; $display("FAIL stop2_busy: got %b exp 0", busy_c); end
    endtask

    task automatic test_overrun;
        rdy_a = 1'b0;
        send_frame(0, 8'h11, 1'b0, 2'b11);
        wait_clks(10);
        checks++; if ({val_a, data_a, ov_a} !== {1'b1, 8'h11, 1'b0}) begin errors++; $display("FAIL ovr_first: got v=%b d=%h o=%b exp v=1 d=11 o=0", val_a, data_a, ov_a); end
        send_frame(0, 8'h22, 1'b0, 2'b11);
        wait_clks(10);
        checks++; if ({val_a, data_a} !== {1'b1, 8'h22}) begin errors++; $display("FAIL ovr_data: got v=%b d=%h exp v=1 d=22", val_a, data_a); end
        checks++; if ({fe_a, pe_a, ov_a} !== 3'b001) begin errors++; $display("FAIL ovr_flags: got %b exp 001", {fe_a, pe_a, ov_a}); end
        rdy_a = 1'b1;
        wait_clks(1);
        rdy_a = 1'b0;
        checks++; if ({val_a, ov_a} !== 2'b00) begin errors++; $display("FAIL ovr_accept: got v=%b o=%b exp 00", val_a, ov_a); end
        rdy_a = 1'b1;
    endtask

    task automatic test_glitch;
        vcnt_a = 0;
        drive(0, 1'b0);
        wait_clks(3);
        checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL glitch_busy_high: got %b exp 1", busy_a); end
        drive(0, 1'b1);
        for (int i = 0; i < 6 && busy_a; i++) wait_clks(1);
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL glitch_busy_clear: got %b exp 0 within 6 clks", busy_a); end
        wait_clks(20);
        checks++; if (vcnt_a !== 0) begin errors++; $display("FAIL glitch_no_valid: got %0d exp 0", vcnt_a); end
    endtask

    task automatic test_reset_mid;
        vcnt_a = 0;
        drive(0, 1'b0); wait_clks(10);
        drive(0, 1'b1); wait_clks(10);
        drive(0, 1'b0); wait_clks(10);
        checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL rmid_busy_before: got %b exp 1", busy_a); end
        reset = 1'b0;
        #1;
        checks++; if ({busy_a, val_a} !== 2'b00) begin errors++; $display("FAIL rmid_abort: got busy=%b valid=%b exp 00", busy_a, val_a); end
        drive(0, 1'b1);
        wait_clks(3);
        reset = 1'b1;
        wait_clks(20);
        send_frame(0, 8'h5A, 1'b0, 2'b11);
        wait_clks(10);
        checks++; if (vcnt_a !== 1) begin errors++; $display("FAIL rmid_count: got %0d exp 1", vcnt_a); end
        checks++; if ({cap_a, flg_a} !== {8'h5A, 3'b000}) begin errors++; $display("FAIL rmid_frame: got %h/%b exp 5a/000", cap_a, flg_a); end
    endtask

    task automatic test_break;
        vcnt_a = 0;
        drive(0, 1'b0);
        wait_clks(300);
`ifdef UART_RX_BREAK_DET_EN
        checks++; if (brk_a !== 1'b1) begin errors++; $display("FAIL brk_set: got %b exp 1", brk_a); end
        checks++; if (vcnt_a !== 0) begin errors++; $display("FAIL brk_no_valid: got %0d exp 0", vcnt_a); end
        checks++; if ({brk_b, brk_c} !== 2'b00) begin errors++; $display("FAIL brk_others: got %b exp 00", {brk_b, brk_c}); end
        drive(0, 1'b1);
        wait_clks(5);
        checks++; if ({brk_a, busy_a} !== 2'b00) begin errors++; $display("FAIL brk_release: got brk=%b busy=%b exp 00", brk_a, busy_a); end
        wait_clks(10);
        send_frame(0, 8'h7E, 1'b0, 2'b11);
        wait_clks(10);
        checks++; if (vcnt_a !== 1) begin errors++; $display("FAIL brk_after_count: got %0d exp 1", vcnt_a); end
`else
        checks++; if (vcnt_a !== 1) begin errors++; $display("FAIL low_count: got %0d exp 1", vcnt_a); end
        checks++; if ({cap_a, flg_a} !== {8'h00, 3'b100}) begin errors++; $display("FAIL low_frame: got %h/%b exp 00/100", cap_a, flg_a); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL low_busy: got %b exp 0", busy_a); end
        drive(0, 1'b1);
        wait_clks(15);
        send_frame(0, 8'h7E, 1'b0, 2'b11);
        wait_clks(10);
        checks++; if (vcnt_a !== 2) begin errors++; $display("FAIL low_after_count: got %0d exp 2", vcnt_a); end
`endif
        checks++; if ({cap_a, flg_a} !== {8'h7E, 3'b000}) begin errors++; $display("FAIL after_break_frame: got %h/%b exp 7e/000", cap_a, flg_a); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_back_to_back;
        test_parity;
        test_two_stop;
        test_overrun;
        test_glitch;
        test_reset_mid;
        test_break;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
